uart_apb_host: RTL and testbench

- APB3 slave front-end that feeds the UART physical layer from the system bus.
- Buffers TX bytes in an internal FIFO and presents its read port to the phy's wr_phy_fifo interface.
- Assembles 40-bit config words from two 32-bit writes into a one-entry mailbox on the phy's config interface.
- Captures bytes from the phy's rd_phy_fifo push port into an RX FIFO that the CPU pops over APB.

---
 rtl/uart_apb_host.sv | 224 ++++++++++++++++++++++
 tb/tb_uart_apb_host.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_apb_host.sv
// uart_apb_host: APB3 slave front-end for the UART physical layer.
//   - TX FIFO filled by APB writes to TXDATA, drained by the phy through
//     wr_phy_fifo_en_i / wr_phy_fifo_data_o / wr_phy_fifo_empty_o.
//   - One-entry config mailbox: CFG_LO then CFG_HI writes commit a 40-bit
//     word onto config_fifo_data_o, popped by config_fifo_en_i.
//   - RX FIFO filled by rd_phy_fifo_en_i / rd_phy_fifo_data_i, popped by
//     APB reads of RXDATA.
//   - Sticky status flags, CTRL interrupt enables, registered irq_o.
// Ports: clk_i/rst_i (sync, active high), APB3 psel/penable/pwrite/paddr/
//   pwdata/prdata/pready/pslverr, phy TX/config/RX strobes, tx_active_i,
//   tx_done_i, irq_o.
module uart_apb_host #(
  parameter int PHY_FIFO_WIDTH    = 8,
  parameter int CONFIG_DATA_WIDTH = 40,
  parameter int FIFO_DEPTH        = 16,
  parameter int FIFO_AW           = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         psel_i,
  input  logic                         penable_i,
  input  logic                         pwrite_i,
  input  logic [7:0]                   paddr_i,
  input  logic [31:0]                  pwdata_i,
  output logic [31:0]                  prdata_o,
  output logic                         pready_o,
  output logic                         pslverr_o,
  output logic                         wr_phy_fifo_empty_o,
  input  logic                         wr_phy_fifo_en_i,
  output logic [PHY_FIFO_WIDTH-1:0]    wr_phy_fifo_data_o,
  output logic                         config_fifo_empty_o,
  input  logic                         config_fifo_en_i,
  output logic [CONFIG_DATA_WIDTH-1:0] config_fifo_data_o,
  input  logic                         rd_phy_fifo_en_i,
  input  logic [PHY_FIFO_WIDTH-1:0]    rd_phy_fifo_data_i,
  input  logic                         tx_active_i,
  input  logic                         tx_done_i,
  output logic                         irq_o
);

  // Word index of each register (paddr_i[7:2]).
  localparam logic [5:0] A_TXDATA = 6'd0;
  localparam logic [5:0] A_RXDATA = 6'd1;
  localparam logic [5:0] A_CFG_LO = 6'd2;
  localparam logic [5:0] A_CFG_HI = 6'd3;
  localparam logic [5:0] A_STATUS = 6'd4;
  localparam logic [5:0] A_CTRL   = 6'd5;
  localparam logic [5:0] A_CLR    = 6'd6;

  localparam int HI_W = CONFIG_DATA_WIDTH - 32;
  localparam logic [FIFO_AW:0] DEPTH_C = (FIFO_AW+1)'(FIFO_DEPTH);

  logic [PHY_FIFO_WIDTH-1:0]    tx_mem_q [FIFO_DEPTH];
  logic [PHY_FIFO_WIDTH-1:0]    rx_mem_q [FIFO_DEPTH];
  logic [FIFO_AW-1:0]           tx_wptr_q, tx_rptr_q, rx_wptr_q, rx_rptr_q;
  logic [FIFO_AW:0]             tx_count_q, tx_count_d, rx_count_q, rx_count_d;
  logic [PHY_FIFO_WIDTH-1:0]    tx_data_q;
  logic [CONFIG_DATA_WIDTH-1:0] cfg_data_q;
  logic                         cfg_empty_q, cfg_empty_d;
  logic [31:0]                  stage_lo_q;
  logic [HI_W-1:0]              stage_hi_q;
  logic [1:0]                   ctrl_q;
  // sticky_q[0]=tx_ovf, [1]=rx_ovf, [2]=txdone; mirrors STATUS[8:6].
  logic [2:0]                   sticky_q, sticky_d;
  logic                         irq_q, irq_d;

  logic        access_s, tx_full_s, tx_empty_s, rx_full_s, rx_empty_s;
  logic        tx_push_s, tx_pop_s, tx_ovf_set_s, rx_push_s, rx_pop_s, rx_ovf_set_s;
  logic        lo_wr_s, hi_wr_s, ctrl_wr_s, clr_wr_s;
  logic [31:0] status_s, prdata_s;
  logic        pslverr_s;
  logic        unused_s;

  assign access_s     = psel_i & penable_i;
  assign tx_full_s    = (tx_count_q == DEPTH_C);
  assign tx_empty_s   = (tx_count_q == '0);
  assign rx_full_s    = (rx_count_q == DEPTH_C);
  assign rx_empty_s   = (rx_count_q == '0);
  assign tx_pop_s     = wr_phy_fifo_en_i & ~tx_empty_s;
  // Full check uses the pre-cycle count, so a concurrent pop never makes room.
  assign rx_push_s    = rd_phy_fifo_en_i & ~rx_full_s;
  assign rx_ovf_set_s = rd_phy_fifo_en_i & rx_full_s;
  assign unused_s     = ^paddr_i[1:0];

  // STATUS register image.
  always_comb begin
    status_s    = 32'h0;
    status_s[0] = tx_empty_s;
    status_s[1] = tx_full_s;
    status_s[2] = rx_empty_s;
    status_s[3] = rx_full_s;
    status_s[4] = tx_active_i;
    status_s[5] = ~cfg_empty_q;
    status_s[8:6] = sticky_q;
    status_s[16 +: FIFO_AW+1] = tx_count_q;
    status_s[24 +: FIFO_AW+1] = rx_count_q;
  end

  // APB decode: read mux, error response and one-cycle side-effect strobes.
  always_comb begin
    prdata_s     = 32'h0;
    pslverr_s    = 1'b0;
    tx_push_s    = 1'b0;
    tx_ovf_set_s = 1'b0;
    rx_pop_s     = 1'b0;
    lo_wr_s      = 1'b0;
    hi_wr_s      = 1'b0;
    ctrl_wr_s    = 1'b0;
    clr_wr_s     = 1'b0;
    if (access_s && pwrite_i) begin
      case (paddr_i[7:2])
        A_TXDATA: begin
          if (tx_full_s) begin
            pslverr_s    = 1'b1;
            tx_ovf_set_s = 1'b1;
          end else begin
            tx_push_s = 1'b1;
          end
        end
        A_CFG_LO: lo_wr_s   = 1'b1;
        A_CFG_HI: hi_wr_s   = 1'b1;
        A_CTRL:   ctrl_wr_s = 1'b1;
        A_CLR:    clr_wr_s  = 1'b1;
        default:  pslverr_s = 1'b1;
      endcase
    end else if (access_s) begin
      case (paddr_i[7:2])
        A_RXDATA: begin
          if (rx_empty_s) begin
            pslverr_s = 1'b1;
          end else begin
            prdata_s = {{(32-PHY_FIFO_WIDTH){1'b0}}, rx_mem_q[rx_rptr_q]};
            rx_pop_s = 1'b1;
          end
        end
        A_CFG_LO: prdata_s  = stage_lo_q;
        A_CFG_HI: prdata_s  = {{(32-HI_W){1'b0}}, stage_hi_q};
        A_STATUS: prdata_s  = status_s;
        A_CTRL:   prdata_s  = {30'h0, ctrl_q};
        default:  pslverr_s = 1'b1;
      endcase
    end else begin
      prdata_s  = 32'h0;
      pslverr_s = 1'b0;
    end
  end

  // Next-state for counts, mailbox flag, sticky flags and interrupt.
  always_comb begin
    tx_count_d = tx_count_q + (FIFO_AW+1)'(tx_push_s) - (FIFO_AW+1)'(tx_pop_s);
    rx_count_d = rx_count_q + (FIFO_AW+1)'(rx_push_s) - (FIFO_AW+1)'(rx_pop_s);
    // A commit beats a same-cycle phy pop.
    if (hi_wr_s) begin
      cfg_empty_d = 1'b0;
    end else if (config_fifo_en_i) begin
      cfg_empty_d = 1'b1;
    end else begin
      cfg_empty_d = cfg_empty_q;
    end
    // Clear first, then set, so a same-cycle event survives the CLR write.
    if (clr_wr_s) begin
      sticky_d = sticky_q & ~pwdata_i[8:6];
    end else begin
      sticky_d = sticky_q;
    end
    sticky_d = sticky_d | {tx_done_i, rx_ovf_set_s, tx_ovf_set_s};
    irq_d = (ctrl_q[0] & ~rx_empty_s) | (ctrl_q[1] & sticky_q[2]);
  end

  // Control state: pointers, counts, output registers, staging, flags.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tx_wptr_q   <= '0;
      tx_rptr_q   <= '0;
      rx_wptr_q   <= '0;
      rx_rptr_q   <= '0;
      tx_count_q  <= '0;
      rx_count_q  <= '0;
      tx_data_q   <= '0;
      cfg_data_q  <= '0;
      cfg_empty_q <= 1'b1;
      stage_lo_q  <= 32'h0;
      stage_hi_q  <= '0;
      ctrl_q      <= 2'b00;
      sticky_q    <= 3'b000;
      irq_q       <= 1'b0;
    end else begin
      if (tx_push_s) tx_wptr_q <= tx_wptr_q + FIFO_AW'(1);
      if (tx_pop_s) begin
        tx_rptr_q <= tx_rptr_q + FIFO_AW'(1);
        tx_data_q <= tx_mem_q[tx_rptr_q];
      end
      if (rx_push_s) rx_wptr_q <= rx_wptr_q + FIFO_AW'(1);
      if (rx_pop_s)  rx_rptr_q <= rx_rptr_q + FIFO_AW'(1);
      tx_count_q  <= tx_count_d;
      rx_count_q  <= rx_count_d;
      if (lo_wr_s) stage_lo_q <= pwdata_i;
      if (hi_wr_s) begin
        stage_hi_q <= pwdata_i[HI_W-1:0];
        cfg_data_q <= {pwdata_i[HI_W-1:0], stage_lo_q};
      end
      cfg_empty_q <= cfg_empty_d;
      if (ctrl_wr_s) ctrl_q <= pwdata_i[1:0];
      sticky_q    <= sticky_d;
      irq_q       <= irq_d;
    end
  end

  // FIFO storage; contents are meaningless once pointers/counts are reset.
  always_ff @(posedge clk_i) begin
    if (tx_push_s) tx_mem_q[tx_wptr_q] <= pwdata_i[PHY_FIFO_WIDTH-1:0];
    if (rx_push_s) rx_mem_q[rx_wptr_q] <= rd_phy_fifo_data_i;
  end

  assign prdata_o            = prdata_s;
  assign pslverr_o           = pslverr_s;
  assign pready_o            = 1'b1;
  assign wr_phy_fifo_empty_o = tx_empty_s;
  assign wr_phy_fifo_data_o  = tx_data_q;
  assign config_fifo_empty_o = cfg_empty_q;
  assign config_fifo_data_o  = cfg_data_q;
  assign irq_o               = irq_q;

endmodule

// File: tb/tb_uart_apb_host.sv
// Testbench for uart_apb_host: directed scenarios with literal expectations,
// then randomized APB/phy traffic, all checked every cycle against a
// queue-based behavioural model.
module tb_uart_apb_host;

  logic        clk = 1'b0;
  logic        rst;
  logic        psel, penable, pwrite;
  logic [7:0]  paddr;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic        pready, pslverr;
  logic        wr_empty, wr_en;
  logic [7:0]  wr_data;
  logic        cfg_empty, cfg_en;
  logic [39:0] cfg_data;
  logic        rd_en;
  logic [7:0]  rd_data;
  logic        tx_active, tx_done;
  logic        irq;

  always #5 clk = ~clk;

  uart_apb_host dut (
    .clk_i(clk), .rst_i(rst),
    .psel_i(psel), .penable_i(penable), .pwrite_i(pwrite), .paddr_i(paddr),
    .pwdata_i(pwdata), .prdata_o(prdata), .pready_o(pready), .pslverr_o(pslverr),
    .wr_phy_fifo_empty_o(wr_empty), .wr_phy_fifo_en_i(wr_en), .wr_phy_fifo_data_o(wr_data),
    .config_fifo_empty_o(cfg_empty), .config_fifo_en_i(cfg_en), .config_fifo_data_o(cfg_data),
    .rd_phy_fifo_en_i(rd_en), .rd_phy_fifo_data_i(rd_data),
    .tx_active_i(tx_active), .tx_done_i(tx_done), .irq_o(irq)
  );

  // Behavioural model state
  logic [7:0]  txq[$];
  logic [7:0]  rxq[$];
  logic [7:0]  m_txout;
  logic [39:0] m_cfg;
  logic        m_pend;
  logic [31:0] m_lo;
  logic [7:0]  m_hi;
  logic [1:0]  m_ctrl;
  logic        m_txovf, m_rxovf, m_txd, m_irq;

  int total = 0;
  int bad = 0;
  logic [31:0] last_prdata;
  logic        last_pslverr;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    txq.delete(); rxq.delete();
    m_txout = 8'h0; m_cfg = 40'h0; m_pend = 1'b0; m_lo = 32'h0; m_hi = 8'h0;
    m_ctrl = 2'b0; m_txovf = 1'b0; m_rxovf = 1'b0; m_txd = 1'b0; m_irq = 1'b0;
  endtask

  function automatic logic [31:0] model_status();
    int tn = txq.size();
    int rn = rxq.size();
    logic [31:0] s = 32'h0;
    s = s | 32'(tn == 0) | (32'(tn == 16) << 1) | (32'(rn == 0) << 2) | (32'(rn == 16) << 3);
    s = s | (32'(tx_active) << 4) | (32'(m_pend) << 5) | (32'(m_txovf) << 6);
    s = s | (32'(m_rxovf) << 7) | (32'(m_txd) << 8) | (32'(tn) << 16) | (32'(rn) << 24);
    return s;
  endfunction

  // Expected APB read data / error for the current inputs and model state.
  task automatic model_read(output logic [31:0] ep, output logic ee);
    int idx = int'(paddr[7:2]);
    ep = 32'h0; ee = 1'b0;
    if (psel && penable) begin
      if (pwrite) begin
        case (idx)
          0: ee = (txq.size() == 16);
          2, 3, 5, 6: ee = 1'b0;
          default: ee = 1'b1;
        endcase
      end else begin
        case (idx)
          1: if (rxq.size() == 0) ee = 1'b1; else ep = {24'h0, rxq[0]};
          2: ep = m_lo;
          3: ep = {24'h0, m_hi};
          4: ep = model_status();
          5: ep = {30'h0, m_ctrl};
          default: ee = 1'b1;
        endcase
      end
    end
  endtask

  // Advance the model across one clock edge using the current inputs.
  task automatic model_update();
    int tn = txq.size();
    int rn = rxq.size();
    int idx = int'(paddr[7:2]);
    logic acc = psel && penable;
    logic nirq;
    if (rst) begin
      model_reset();
    end else begin
      nirq = (m_ctrl[0] && rn != 0) || (m_ctrl[1] && m_txd);
      if (wr_en && tn != 0) m_txout = txq.pop_front();
      if (acc && pwrite) begin
        case (idx)
          0: if (tn == 16) m_txovf = 1'b1; else txq.push_back(pwdata[7:0]);
          2: m_lo = pwdata;
          3: begin m_hi = pwdata[7:0]; m_cfg = {pwdata[7:0], m_lo}; end
          5: m_ctrl = pwdata[1:0];
          6: begin
            if (pwdata[6]) m_txovf = 1'b0;
            if (pwdata[7]) m_rxovf = 1'b0;
            if (pwdata[8]) m_txd = 1'b0;
          end
          default: ;
        endcase
      end
      if (acc && !pwrite && idx == 1 && rn != 0) void'(rxq.pop_front());
      if (rd_en) begin
        if (rn == 16) m_rxovf = 1'b1; else rxq.push_back(rd_data);
      end
      if (acc && pwrite && idx == 3) m_pend = 1'b1;
      else if (cfg_en) m_pend = 1'b0;
      if (tx_done) m_txd = 1'b1;
      m_irq = nirq;
    end
  endtask

  // One clock: entered at a negedge with inputs applied; compare, then advance.
  task automatic step();
    logic [31:0] ep;
    logic        ee;
    #2;
    model_read(ep, ee);
    chk("prdata", prdata, ep);
    chk("pslverr", pslverr, ee);
    chk("pready", pready, 1'b1);
    chk("wr_empty", wr_empty, txq.size() == 0);
    chk("wr_data", wr_data, m_txout);
    chk("cfg_empty", cfg_empty, !m_pend);
    chk("cfg_data", cfg_data, m_cfg);
    chk("irq", irq, m_irq);
    last_prdata  = prdata;
    last_pslverr = pslverr;
    model_update();
    @(negedge clk);
  endtask

  task automatic apb(input logic w, input logic [7:0] a, input logic [31:0] d);
    psel = 1'b1; penable = 1'b0; pwrite = w; paddr = a; pwdata = d;
    step();
    penable = 1'b1;
    step();
    psel = 1'b0; penable = 1'b0;
  endtask

  initial begin
    logic [7:0] a;
    rst = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = 8'h0; pwdata = 32'h0;
    wr_en = 1'b0; cfg_en = 1'b0; rd_en = 1'b0; rd_data = 8'h0; tx_active = 1'b0; tx_done = 1'b0;
    @(negedge clk);
    model_reset();
    step();
    rst = 1'b0;
    step();

    // Reset state
    apb(1'b0, 8'h10, 32'h0);
    chk("reset_status", last_prdata, 32'h5);
    chk("reset_wr_empty", wr_empty, 1'b1);
    chk("reset_cfg_empty", cfg_empty, 1'b1);
    chk("reset_irq", irq, 1'b0);

    // Two TX bytes popped by the phy
    apb(1'b1, 8'h00, 32'h41);
    apb(1'b1, 8'h00, 32'h42);
    wr_en = 1'b1; step(); wr_en = 1'b0;
    chk("tx_byte0", wr_data, 8'h41);
    step();
    wr_en = 1'b1; step(); wr_en = 1'b0;
    chk("tx_byte1", wr_data, 8'h42);
    chk("tx_drained", wr_empty, 1'b1);

    // TX overflow
    for (int i = 0; i < 17; i++) apb(1'b1, 8'h00, 32'(i));
    chk("tx_ovf_err", last_pslverr, 1'b1);
    apb(1'b0, 8'h10, 32'h0);
    chk("tx_ovf_bit", last_prdata[6], 1'b1);
    chk("tx_count16", last_prdata[20:16], 5'd16);
    apb(1'b1, 8'h18, 32'h40);
    apb(1'b0, 8'h10, 32'h0);
    chk("tx_ovf_clr", last_prdata[6], 1'b0);
    wr_en = 1'b1;
    repeat (17) step();
    wr_en = 1'b0;

    // Config mailbox
    apb(1'b1, 8'h08, 32'h0001C200);
    apb(1'b1, 8'h0C, 32'h08);
    chk("cfg_word", cfg_data, 40'h080001C200);
    chk("cfg_pending", cfg_empty, 1'b0);
    cfg_en = 1'b1; step(); cfg_en = 1'b0;
    chk("cfg_popped", cfg_empty, 1'b1);
    chk("cfg_held", cfg_data, 40'h080001C200);

    // RX byte and interrupt
    rd_en = 1'b1; rd_data = 8'h5A; step(); rd_en = 1'b0;
    apb(1'b1, 8'h14, 32'h1);
    step();
    chk("rx_irq", irq, 1'b1);
    apb(1'b0, 8'h04, 32'h0);
    chk("rx_data", last_prdata, 32'h5A);
    step();
    chk("rx_irq_drop", irq, 1'b0);
    apb(1'b0, 8'h04, 32'h0);
    chk("rx_empty_data", last_prdata, 32'h0);
    chk("rx_empty_err", last_pslverr, 1'b1);
    apb(1'b1, 8'h10, 32'h0);
    chk("wrong_dir_err", last_pslverr, 1'b1);

    // tx_done set beats a same-cycle CLR
    apb(1'b1, 8'h14, 32'h2);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h18; pwdata = 32'h100;
    step();
    penable = 1'b1; tx_done = 1'b1;
    step();
    psel = 1'b0; penable = 1'b0; tx_done = 1'b0;
    apb(1'b0, 8'h10, 32'h0);
    chk("txdone_sticky", last_prdata[8], 1'b1);
    chk("txdone_irq", irq, 1'b1);

    // Reset mid-burst
    apb(1'b1, 8'h00, 32'h11);
    apb(1'b1, 8'h0C, 32'h33);
    rd_en = 1'b1; rd_data = 8'h77; step(); rd_en = 1'b0;
    rst = 1'b1; step(); rst = 1'b0;
    step();
    chk("rst_wr_empty", wr_empty, 1'b1);
    chk("rst_cfg_empty", cfg_empty, 1'b1);
    chk("rst_irq", irq, 1'b0);
    apb(1'b0, 8'h10, 32'h0);
    chk("rst_status", last_prdata, 32'h5);

    // Randomized traffic
    for (int n = 0; n < 1500; n++) begin
      wr_en     = ($urandom_range(0, 3) == 0);
      cfg_en    = ($urandom_range(0, 3) == 0);
      rd_en     = ($urandom_range(0, 2) == 0);
      rd_data   = 8'($urandom);
      tx_active = 1'($urandom);
      tx_done   = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 499) == 0) begin
        rst = 1'b1; step(); rst = 1'b0;
      end else if ($urandom_range(0, 2) == 0) begin
        step();
      end else begin
        if ($urandom_range(0, 15) == 0) a = 8'($urandom);
        else if ($urandom_range(0, 2) == 0) a = 8'h00;
        else a = 8'($urandom_range(0, 7)) << 2;
        apb(1'($urandom), a, $urandom);
      end
    end
    wr_en = 1'b0; cfg_en = 1'b0; rd_en = 1'b0; tx_done = 1'b0;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
